// File: rtl/bcd_scan_display.sv
// bcd_scan_display: time-multiplexed common-anode 7-segment driver for DIGITS packed BCD digits.
// Ports: CLK clock; CR sync active-high clear; BCD packed digits (digit k = BCD[4k+3:4k]);
//        DP_IN per-digit decimal point request; SEG {g..a} active-low; DP active-low; AN active-low digit enables.
// Optional macro LEADING_ZERO_BLANK_EN: blank leading zero digits (digit 0 never blanked).
module bcd_scan_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  CLK,
  input  logic                  CR,
  input  logic [4*DIGITS-1:0]   BCD,
  input  logic [DIGITS-1:0]     DP_IN,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic [DIGITS-1:0]     AN
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [PW-1:0]       pre;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] snap, snap_sh;
  logic [DIGITS-1:0]   snap_dp, dp_sh, an_next;
  logic                load_pend, tick, last, dp_sel, blank;
  logic [3:0]          dig;
  logic [6:0]          seg_dec;
  assign tick    = pre == PW'(SCAN_DIV - 1);
  assign last    = idx == IW'(DIGITS - 1);
  assign snap_sh = snap >> (4 * idx);
  assign dig     = snap_sh[3:0];
  assign dp_sh   = snap_dp >> idx;
  assign dp_sel  = dp_sh[0];
  assign an_next = ~(DIGITS'(1) << idx);
  always_comb begin
    seg_dec = 7'h3F;
    case (dig)
      4'd0: seg_dec = 7'h40;
      4'd1: seg_dec = 7'h79;
      4'd2: seg_dec = 7'h24;
      4'd3: seg_dec = 7'h30;
      4'd4: seg_dec = 7'h19;
      4'd5: seg_dec = 7'h12;
      4'd6: seg_dec = 7'h02;
      4'd7: seg_dec = 7'h78;
      4'd8: seg_dec = 7'h00;
      4'd9: seg_dec = 7'h10;
      default: seg_dec = 7'h3F;
    endcase
  end
`ifdef LEADING_ZERO_BLANK_EN
  // lz[k] = digit k and every more-significant digit of the snapshot are zero
  logic [DIGITS-1:0] lz, lz_sh;
  for (genvar k = 0; k < DIGITS; k++) begin : g_lz
    if (k == DIGITS - 1) begin : g_top
      assign lz[k] = snap[4*k +: 4] == 4'd0;
    end else begin : g_mid
      assign lz[k] = (snap[4*k +: 4] == 4'd0) & lz[k+1];
    end
  end
  assign lz_sh = lz >> idx;
  assign blank = (idx != '0) & lz_sh[0] & ~dp_sel;
`else
  assign blank = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (CR) begin
      pre       <= '0;
      idx       <= '0;
      snap      <= '0;
      snap_dp   <= '0;
      load_pend <= 1'b1;
      AN        <= '1;
      SEG       <= 7'h7F;
      DP        <= 1'b1;
    end else begin
      pre       <= tick ? '0 : pre + 1'b1;
      idx       <= tick ? (last ? '0 : idx + 1'b1) : idx;
      // snapshot only at frame boundaries so a frame never mixes two counter values
      snap      <= (load_pend | (tick & last)) ? BCD : snap;
      snap_dp   <= (load_pend | (tick & last)) ? DP_IN : snap_dp;
      load_pend <= 1'b0;
      AN        <= an_next;
      SEG       <= blank ? 7'h7F : seg_dec;
      DP        <= ~dp_sel;
    end
  end
endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: scoreboard bench for bcd_scan_display with DIGITS=4, SCAN_DIV=4.
module tb_bcd_scan_display;
  logic        CLK = 1'b0;
  logic        CR = 1'b1;
  logic [15:0] BCD = '0;
  logic [3:0]  DP_IN = '0;
  logic [6:0]  SEG;
  logic        DP;
  logic [3:0]  AN;
  bcd_scan_display #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .CLK(CLK), .CR(CR), .BCD(BCD), .DP_IN(DP_IN), .SEG(SEG), .DP(DP), .AN(AN)
  );
  always #5 CLK = ~CLK;
  logic [11:0] q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          n = 0;
  logic [15:0] m_snap = '0;
  logic [3:0]  m_dp = '0;
  logic [6:0]  dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  task automatic step(input string tag);
    logic [11:0] e, got;
    int i;
    if (CR) begin
      e = {4'hF, 7'h7F, 1'b1};
      n = 0;
      m_snap = '0;
      m_dp = '0;
    end else begin
      i = (n / 4) % 4;
      e[11:8] = 4'(~(4'b1 << i));
      e[7:1]  = dec_tab[m_snap[4*i +: 4]];
      e[0]    = ~m_dp[i];
`ifdef LEADING_ZERO_BLANK_EN
      if (i != 0 && !m_dp[i] && (m_snap >> (4 * i)) == 16'd0) e[7:1] = 7'h7F;
`endif
      if (n == 0 || n % 16 == 15) begin
        m_snap = BCD;
        m_dp = DP_IN;
      end
      n++;
    end
    q.push_back(e);
    @(posedge CLK);
    #1;
    got = {AN, SEG, DP};
    e = q.pop_front();
    compared++;
    assert (got === e) else begin
      mismatched++;
      $error("FAIL %s n=%0d AN/SEG/DP got %b/%h/%b expected %b/%h/%b",
             tag, n, got[11:8], got[7:1], got[0], e[11:8], e[7:1], e[0]);
    end
  endtask
  task automatic run(input int k, input string tag);
    for (int j = 0; j < k; j++) step(tag);
  endtask
  initial begin
    CR = 1'b1;
    run(3, "reset");
    CR = 1'b0;
    BCD = 16'h1234;
    run(32, "scan_1234");
    run(5, "pre_coherence");
    BCD = 16'h5678;
    run(43, "coherence_5678");
    BCD = 16'hA0F9;
    DP_IN = 4'b0100;
    run(32, "invalid_dp");
    run(9, "to_idx2");
    CR = 1'b1;
    run(1, "reset_mid");
    CR = 1'b0;
    run(20, "restart");
    DP_IN = 4'b0000;
    BCD = 16'h0050;
    run(32, "lzb_0050");
    BCD = 16'h0000;
    run(32, "lzb_0000");
    compared++;
    assert (q.size() == 0) else begin
      mismatched++;
      $error("FAIL queue_drain got %0d entries expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
